// File: rtl/stopwatch_watch_datapath_pkg.sv
// Shared field widths, terminal values, mode encoding and time record for the
// stopwatch/watch datapath.
package stopwatch_watch_datapath_pkg;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  localparam logic MODE_STOPWATCH = 1'b0;
  localparam logic MODE_WATCH     = 1'b1;

  typedef enum logic [1:0] {
    ADJ_SEC  = 2'd0,
    ADJ_MIN  = 2'd1,
    ADJ_HOUR = 2'd2
  } adj_sel_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } time_t;

endpackage

// File: rtl/stopwatch_watch_datapath_tick_gen.sv
// Free-running divider producing a registered one-cycle pulse at TICK_HZ.
module stopwatch_watch_datapath_tick_gen #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/stopwatch_watch_datapath_time_counter_chain.sv
// msec->sec->min->hour counter chain with clear, single-field adjust and tick ripple.
// Priority: clear > adjust > tick; an adjust never carries into another field.
module stopwatch_watch_datapath_time_counter_chain
  import stopwatch_watch_datapath_pkg::*;
#(
  parameter logic [HOUR_W-1:0] INIT_HOUR = '0
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     tick_en,
  input  logic     clear,
  input  adj_sel_e adj_sel,
  input  logic     adj_dir,
  input  logic     adj_en,
  output time_t    t
);

  localparam time_t RST = '{hour: INIT_HOUR, min: '0, sec: '0, msec: '0};

  time_t nxt;
  logic  msec_wrap, sec_wrap, min_wrap;

  assign msec_wrap = (t.msec == MSEC_MAX);
  assign sec_wrap  = (t.sec  == SEC_MAX);
  assign min_wrap  = (t.min  == MIN_MAX);

  always_comb begin
    nxt = t;
    if (clear) begin
      nxt = '0;
    end else if (adj_en) begin
      case (adj_sel)
        ADJ_HOUR: nxt.hour = adj_dir ? ((t.hour == '0) ? HOUR_MAX : t.hour - HOUR_W'(1))
                                     : ((t.hour == HOUR_MAX) ? '0 : t.hour + HOUR_W'(1));
        ADJ_MIN:  nxt.min  = adj_dir ? ((t.min == '0) ? MIN_MAX : t.min - MIN_W'(1))
                                     : (min_wrap ? '0 : t.min + MIN_W'(1));
        ADJ_SEC: begin
          nxt.sec  = adj_dir ? ((t.sec == '0) ? SEC_MAX : t.sec - SEC_W'(1))
                             : (sec_wrap ? '0 : t.sec + SEC_W'(1));
          nxt.msec = '0;
        end
        default: ;
      endcase
    end else if (tick_en) begin
      // Full ripple in one cycle: 23:59:59.99 rolls straight to 00:00:00.00.
      nxt.msec = msec_wrap ? '0 : t.msec + MSEC_W'(1);
      if (msec_wrap) begin
        nxt.sec = sec_wrap ? '0 : t.sec + SEC_W'(1);
        if (sec_wrap) begin
          nxt.min = min_wrap ? '0 : t.min + MIN_W'(1);
          if (min_wrap)
            nxt.hour = (t.hour == HOUR_MAX) ? '0 : t.hour + HOUR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) t <= RST;
    else          t <= nxt;
  end

endmodule

// File: rtl/stopwatch_watch_datapath.sv
// Stopwatch/watch datapath: shared tick, two counter chains, button priority
// and the mode-selected display mux.
module stopwatch_watch_datapath
  import stopwatch_watch_datapath_pkg::*;
#(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int WATCH_INIT_HOUR = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_mode,
  input  logic              i_run_stop,
  input  logic              i_clear,
  input  logic              i_sw1,
  input  logic              i_btn1,
  input  logic              i_btn2,
  input  logic              i_btn3,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_tick
);

  logic     tick, adj;
  adj_sel_e sel;
  time_t    sw, wt, disp;

  stopwatch_watch_datapath_tick_gen #(
    .CLK_FREQ(CLK_FREQ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // Buttons only count in watch mode; hour beats min beats sec.
  assign adj = (i_mode == MODE_WATCH) && (i_btn1 || i_btn2 || i_btn3);

  always_comb begin
    sel = ADJ_SEC;
    if (i_btn1)      sel = ADJ_HOUR;
    else if (i_btn2) sel = ADJ_MIN;
  end

  stopwatch_watch_datapath_time_counter_chain #(
    .INIT_HOUR('0)
  ) u_sw (
    .clk    (clk),
    .reset_n(reset_n),
    .tick_en(tick & i_run_stop),
    .clear  (i_clear),
    .adj_sel(ADJ_SEC),
    .adj_dir(1'b0),
    .adj_en (1'b0),
    .t      (sw)
  );

  stopwatch_watch_datapath_time_counter_chain #(
    .INIT_HOUR(HOUR_W'(WATCH_INIT_HOUR))
  ) u_watch (
    .clk    (clk),
    .reset_n(reset_n),
    .tick_en(tick),
    .clear  (1'b0),
    .adj_sel(sel),
    .adj_dir(i_sw1),
    .adj_en (adj),
    .t      (wt)
  );

  assign disp   = (i_mode == MODE_WATCH) ? wt : sw;
  assign o_msec = disp.msec;
  assign o_sec  = disp.sec;
  assign o_min  = disp.min;
  assign o_hour = disp.hour;
  assign o_tick = tick;

endmodule

// File: tb/tb_stopwatch_watch_datapath.sv
// Directed bench: 10-clock tick period; expected times are hand-derived from the
// edge count since reset release.
module tb_stopwatch_watch_datapath;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_mode = 1'b0, i_run_stop = 1'b0, i_clear = 1'b0, i_sw1 = 1'b0;
  logic       i_btn1 = 1'b0, i_btn2 = 1'b0, i_btn3 = 1'b0;
  logic [6:0] o_msec;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  logic       o_tick;
  logic [31:0] disp;

  int checks = 0;
  int errors = 0;

  stopwatch_watch_datapath #(
    .CLK_FREQ       (1000),
    .TICK_HZ        (100),
    .WATCH_INIT_HOUR(12)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_mode    (i_mode),
    .i_run_stop(i_run_stop),
    .i_clear   (i_clear),
    .i_sw1     (i_sw1),
    .i_btn1    (i_btn1),
    .i_btn2    (i_btn2),
    .i_btn3    (i_btn3),
    .o_msec    (o_msec),
    .o_sec     (o_sec),
    .o_min     (o_min),
    .o_hour    (o_hour),
    .o_tick    (o_tick)
  );

  always #5 clk = ~clk;

  assign disp = {8'd0, o_hour, o_min, o_sec, o_msec};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tv(input int h, input int m, input int s, input int ms);
    return {8'd0, h[4:0], m[5:0], s[5:0], ms[6:0]};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic b1, input logic b2, input logic b3);
    i_btn1 = b1; i_btn2 = b2; i_btn3 = b3;
    step(1);
    i_btn1 = 1'b0; i_btn2 = 1'b0; i_btn3 = 1'b0;
  endtask

  initial begin
    // reset state
    step(2);
    chk("rst_sw", disp, tv(0, 0, 0, 0));
    chk("rst_tick", {31'd0, o_tick}, 32'd0);
    i_mode = 1'b1;
    #1 chk("rst_watch", disp, tv(12, 0, 0, 0));
    i_mode = 1'b0;
    reset_n = 1'b1;

    // idle stopwatch, watch free-running (E = edges since release)
    step(101);                                   // E=101
    chk("sw_idle", disp, tv(0, 0, 0, 0));
    i_mode = 1'b1;
    #1 chk("watch_free", disp, tv(12, 0, 0, 10));

    // run stopwatch for 1000 ticks
    i_mode = 1'b0;
    i_run_stop = 1'b1;
    step(9999);                                  // E=10100
    chk("tick_high", {31'd0, o_tick}, 32'd1);
    chk("sw_pre", disp, tv(0, 0, 9, 99));
    step(1);                                     // E=10101
    chk("tick_low", {31'd0, o_tick}, 32'd0);
    chk("sw_10s", disp, tv(0, 0, 10, 0));
    i_run_stop = 1'b0;
    step(500);                                   // E=10601
    chk("sw_hold", disp, tv(0, 0, 10, 0));
    i_clear = 1'b1;
    step(1);                                     // E=10602
    i_clear = 1'b0;
    chk("sw_clear", disp, tv(0, 0, 0, 0));
    i_mode = 1'b1;
    #1 chk("watch_mode_sw", disp, tv(12, 0, 10, 60));

    // adjust down to 23:59:59
    i_sw1 = 1'b1;
    repeat (12) pulse(1'b1, 1'b0, 1'b0);
    chk("hour_to0", {27'd0, o_hour}, 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("hour_wrap_dn", {27'd0, o_hour}, 32'd23);
    pulse(1'b0, 1'b1, 1'b0);
    chk("min_wrap_dn", {21'd0, o_hour, o_min}, {21'd0, 5'd23, 6'd59});
    repeat (11) pulse(1'b0, 1'b0, 1'b1);         // E=10627
    chk("sec_wrap_dn", disp, tv(23, 59, 59, 0));
    step(984);                                   // E=11611
    chk("pre_rollover", disp, tv(23, 59, 59, 99));
    step(10);                                    // E=11621
    chk("rollover", disp, tv(0, 0, 0, 0));

    // btn1+btn3 together, aligned with the tick
    step(9);                                     // E=11630
    chk("tick_align", {31'd0, o_tick}, 32'd1);
    i_sw1 = 1'b0;
    pulse(1'b1, 1'b0, 1'b1);                     // E=11631
    chk("prio_drop", disp, tv(1, 0, 0, 0));
    step(10);                                    // E=11641
    chk("resume", disp, tv(1, 0, 0, 1));
    i_mode = 1'b0;
    pulse(1'b0, 1'b1, 1'b0);                     // E=11642
    i_mode = 1'b1;
    #1 chk("btn_ignored", disp, tv(1, 0, 0, 1));

    // asynchronous reset mid-count
    i_mode = 1'b0;
    i_run_stop = 1'b1;
    step(25);                                    // E=11667
    chk("sw_run2", disp, tv(0, 0, 0, 2));
    #2 reset_n = 1'b0;
    #1 chk("async_rst_sw", disp, tv(0, 0, 0, 0));
    chk("async_rst_tick", {31'd0, o_tick}, 32'd0);
    i_mode = 1'b1;
    #1 chk("async_rst_watch", disp, tv(12, 0, 0, 0));
    i_mode = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(10);
    chk("post_rst_tick", {31'd0, o_tick}, 32'd1);
    chk("post_rst_sw0", disp, tv(0, 0, 0, 0));
    step(1);
    chk("post_rst_sw1", disp, tv(0, 0, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_watch_datapath.md
Name: stopwatch_watch_datapath

Overview:
- Consumer end of the stopwatch/watch control interface. Takes the mode, run/stop, clear, switch and button outputs of the control FSM and owns all time-keeping state.
- Contains a centisecond tick generator, a stopwatch counter chain gated by run/clear, and a free-running watch counter chain with button adjust.
- Drives the selected time fields to the FND/display formatter.

Parameters:
- CLK_FREQ, 100_000_000, input clock frequency in Hz.
- TICK_HZ, 100, counter base rate in Hz. Must divide CLK_FREQ.
- WATCH_INIT_HOUR, 12, watch hour value loaded at reset (0-23).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- i_mode  input  1  0 = display stopwatch, 1 = display watch.
- i_run_stop  input  1  level; 1 = stopwatch counts.
- i_clear  input  1  1-cycle pulse; zeroes the stopwatch.
- i_sw1  input  1  watch adjust direction; 0 = up, 1 = down.
- i_btn1  input  1  1-cycle pulse; adjust watch hour.
- i_btn2  input  1  1-cycle pulse; adjust watch minute.
- i_btn3  input  1  1-cycle pulse; adjust watch second.
- o_msec  output  7  centiseconds 0-99 of the selected chain.
- o_sec  output  6  seconds 0-59 of the selected chain.
- o_min  output  6  minutes 0-59 of the selected chain.
- o_hour  output  5  hours 0-23 of the selected chain.
- o_tick  output  1  1-cycle pulse at TICK_HZ (for the display blink logic).

Behaviour:
- Clock, reset and tick
  - One clock domain. reset_n low asynchronously forces all state to reset values.
  - Reset values: tick divider 0; stopwatch 00:00:00.00; watch WATCH_INIT_HOUR:00:00.00; o_tick 0.
  - Output values seen during reset: o_hour shows 0 (i_mode=0) or WATCH_INIT_HOUR (i_mode=1).
  - Tick divider counts 0..CLK_FREQ/TICK_HZ-1 and wraps. o_tick is registered, high for exactly the one cycle after the divider wraps.
  - Tick is free-running and shared by both chains. It is never reset by i_clear.
- Counter chains
  - Each chain is msec -> sec -> min -> hour. Wraps: 99->0 carries to sec; 59->0 carries to min; 59->0 carries to hour; 23->0 with no further carry.
  - All fields update in the same cycle as a ripple, e.g. 23:59:59.99 + tick -> 00:00:00.00.
  - Latency: a field changes on the clock edge after o_tick is sampled high, i.e. one cycle after the tick pulse.
- Stopwatch
  - Advances on tick only while i_run_stop=1. Holds otherwise.
  - i_clear=1 forces all stopwatch fields to 0 on the next edge, whatever the state of i_run_stop or the tick.
- Watch
  - Advances on every tick regardless of i_mode.
  - Adjust is accepted only when i_mode=1. btn1/btn2/btn3 act on hour/min/sec.
  - Up: +1 with modulo wrap (59->0, 23->0). Down: -1 with wrap (0->59, 0->23). Adjust never carries into another field.
  - Adjusting sec also zeroes msec.
  - Simultaneous pulses: priority btn1 > btn2 > btn3. Only one field adjusts per cycle.
  - In a cycle with an accepted adjust pulse, the watch tick increment is dropped (one centisecond lost, accepted).
  - Button pulses with i_mode=0 are ignored.
- Output selection
  - Outputs are a combinational mux of registered fields selected by i_mode.
  - A mode switch changes the displayed values in the same cycle and never disturbs either chain.
- Width rules: all counters are unsigned at the output widths. Comparisons use terminal values 99/59/23. No out-of-range value is ever reachable.

Decomposition:
- Shared package/header: field widths (MSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5), terminal constants (MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23), MODE_STOPWATCH=0, MODE_WATCH=1.
- Sub-module tick_gen(CLK_FREQ, TICK_HZ) -> o_tick.
- Sub-module time_counter_chain, instantiated twice: inputs tick_en, clear, adj_sel[1:0], adj_dir, adj_en; INIT_HOUR parameter. The stopwatch instance ties the adjust inputs off.
- The top level holds only the enable/priority logic and the output mux.

Test Plan (bench uses CLK_FREQ=1000, TICK_HZ=100, so one tick every 10 clocks):
- Release reset_n, hold i_run_stop=0, i_mode=0 for 100 clocks -> outputs stay 0:00:00.00. Switch i_mode=1 -> o_hour=12, watch o_msec=10.
- i_run_stop=1 for 1000 ticks -> stopwatch reads 00:00:10.00. Drop run for 50 ticks -> value holds. Pulse i_clear -> all 0 on the next edge.
- Preload the watch via adjust to 23:59:59 and let msec reach 99, then one tick -> 00:00:00.00 on both the sec and hour wrap.
- i_mode=1, i_sw1=1, pulse i_btn2 with min=0 -> min=59, hour unchanged. Pulse i_btn1 with hour=0 -> 23.
- Pulse i_btn1 and i_btn3 in the same cycle -> only hour changes. Align the pulse with o_tick -> msec does not advance that cycle.
- Assert reset_n low mid-count, asynchronously between edges -> outputs return to reset values immediately, and counting resumes from zero after release.
